// File: rtl/lcd_spectrum_show_if.sv
// rtl/lcd_spectrum_show_if.sv - band level write port (valid/ready)
interface lcd_spectrum_show_if #(
  parameter int LEVEL_W = 8
);
  logic               band_valid;
  logic               band_ready;
  logic [4:0]         band_idx;
  logic [LEVEL_W-1:0] band_level;

  modport master (
    output band_valid,
    output band_idx,
    output band_level,
    input  band_ready
  );

  modport slave (
    input  band_valid,
    input  band_idx,
    input  band_level,
    output band_ready
  );
endinterface

// File: rtl/lcd_spectrum_show.sv
// rtl/lcd_spectrum_show.sv - per-band level bar graph with peak hold, double-buffered levels
module lcd_spectrum_show #(
  parameter int          NUM_BANDS    = 16,
  parameter int          LEVEL_W      = 8,
  parameter int          BAND_SHIFT   = 5,
  parameter int          GAP          = 4,
  parameter int          DECAY_FRAMES = 4,
  parameter logic [15:0] BAR_COLOR    = 16'h07E0,
  parameter logic [15:0] PEAK_COLOR   = 16'hF800,
  parameter logic [15:0] BG_COLOR     = 16'h0000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  lcd_spectrum_show_if.slave       band_if,
  input  logic [10:0]              pixel_x,
  input  logic [10:0]              pixel_y,
  input  logic [10:0]              h_res,
  input  logic [10:0]              v_res,
  output logic [15:0]              pixel_data,
  output logic                     frame_tick
);
  localparam int                BIDX_W    = $clog2(NUM_BANDS);
  localparam int                DCNT_W    = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam logic [10:0]       NB_11     = 11'(NUM_BANDS);
  localparam logic [10:0]       COL_MASK  = 11'((1 << BAND_SHIFT) - 1);
  localparam logic [10:0]       COL_LIM   = 11'((1 << BAND_SHIFT) - GAP);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_FRAMES - 1);

  logic [LEVEL_W-1:0] r_wr_lvl   [NUM_BANDS];
  logic [LEVEL_W-1:0] r_disp_lvl [NUM_BANDS];
  logic [LEVEL_W-1:0] r_peak     [NUM_BANDS];
  logic [DCNT_W-1:0]  r_dcnt     [NUM_BANDS];

  logic              r_origin_d;
  logic              r_band_ready;
  logic              r_frame_tick;
  logic [BIDX_W-1:0] r_band;
  logic [10:0]       r_row;
  logic              r_blank;
  logic              r_gap;

  logic              w_at_origin;
  logic              w_frame_start;
  logic              w_wr_en;
  logic [BIDX_W-1:0] w_wr_sel;
  logic [10:0]       w_band;
  logic [10:0]       w_row;
  logic              w_blank;
  logic              w_gap;
  logic [10:0]       w_lvl_11;
  logic [10:0]       w_peak_11;

  assign w_at_origin   = (pixel_x == 11'd0) && (pixel_y == 11'd0);
  assign w_frame_start = w_at_origin && !r_origin_d;
  // Out-of-range indices complete the handshake but never touch the store
  assign w_wr_en  = band_if.band_valid && r_band_ready &&
                    ({1'b0, band_if.band_idx} < 6'(NUM_BANDS));
  assign w_wr_sel = band_if.band_idx[BIDX_W-1:0];

  assign band_if.band_ready = r_band_ready;
  assign frame_tick         = r_frame_tick;

  // Detector starts primed so a reset release at (0,0) is not a frame start
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_origin_d   <= 1'b1;
      r_band_ready <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_origin_d   <= w_at_origin;
      r_frame_tick <= w_frame_start;
      r_band_ready <= !w_frame_start;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        r_wr_lvl[i]   <= '0;
        r_disp_lvl[i] <= '0;
        r_peak[i]     <= '0;
        r_dcnt[i]     <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_wr_lvl[w_wr_sel] <= band_if.band_level;
      end
      if (r_frame_tick) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          r_disp_lvl[i] <= r_wr_lvl[i];
          if (r_wr_lvl[i] >= r_peak[i]) begin
            r_peak[i] <= r_wr_lvl[i];
            r_dcnt[i] <= '0;
          end else if (r_dcnt[i] == DCNT_LAST) begin
            r_peak[i] <= r_peak[i] - LEVEL_W'(1);
            r_dcnt[i] <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + DCNT_W'(1);
          end
        end
      end
    end
  end

  assign w_band  = pixel_x >> BAND_SHIFT;
  assign w_row   = v_res - 11'd1 - pixel_y;
  assign w_blank = (pixel_x >= h_res) || (pixel_y >= v_res) || (w_band >= NB_11);
  assign w_gap   = (pixel_x & COL_MASK) >= COL_LIM;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_band  <= '0;
      r_row   <= '0;
      r_blank <= 1'b1;
      r_gap   <= 1'b0;
    end else begin
      r_band  <= w_band[BIDX_W-1:0];
      r_row   <= w_row;
      r_blank <= w_blank;
      r_gap   <= w_gap;
    end
  end

  assign w_lvl_11  = 11'(r_disp_lvl[r_band]);
  assign w_peak_11 = 11'(r_peak[r_band]);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pixel_data <= BG_COLOR;
    end else if (r_blank || r_gap) begin
      pixel_data <= BG_COLOR;
    end else if ((w_peak_11 != 11'd0) && (r_row == w_peak_11)) begin
      pixel_data <= PEAK_COLOR;
    end else if (r_row < w_lvl_11) begin
      pixel_data <= BAR_COLOR;
    end else begin
      pixel_data <= BG_COLOR;
    end
  end
endmodule

// File: tb/tb_lcd_spectrum_show.sv
// tb/tb_lcd_spectrum_show.sv - directed self-checking bench for lcd_spectrum_show
module tb_lcd_spectrum_show;
  localparam logic [15:0] BAR  = 16'h07E0;
  localparam logic [15:0] PEAK = 16'hF800;
  localparam logic [15:0] BG   = 16'h0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [10:0] pixel_x, pixel_y, h_res, v_res;
  logic [15:0] pixel_data;
  logic        frame_tick;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  lcd_spectrum_show_if #(.LEVEL_W(8)) band_if ();

  lcd_spectrum_show dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .band_if    (band_if),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .h_res      (h_res),
    .v_res      (v_res),
    .pixel_data (pixel_data),
    .frame_tick (frame_tick)
  );

  task automatic show(input int x, input int y, output logic [15:0] d);
    @(negedge sys_clk);
    pixel_x = 11'(x);
    pixel_y = 11'(y);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    d = pixel_data;
  endtask

  task automatic write_band(input int idx, input int lvl);
    @(negedge sys_clk);
    band_if.band_valid = 1'b1;
    band_if.band_idx   = 5'(idx);
    band_if.band_level = 8'(lvl);
    for (int i = 0; i < 10 && !band_if.band_ready; i++) @(negedge sys_clk);
    n_tests++;
    if (band_if.band_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_accept idx=%0d: band_ready=%b required 1", idx, band_if.band_ready);
    end else begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    band_if.band_valid = 1'b0;
  endtask

  task automatic do_frame();
    int ticks = 0;
    @(negedge sys_clk);
    pixel_x = 11'd0;
    pixel_y = 11'd0;
    repeat (6) begin
      @(negedge sys_clk);
      if (frame_tick === 1'b1) ticks++;
    end
    pixel_x = 11'd600;
    pixel_y = 11'd600;
    repeat (2) begin
      @(negedge sys_clk);
      if (frame_tick === 1'b1) ticks++;
    end
    n_tests++;
    if (ticks !== 1) begin
      n_fail++;
      $display("FAIL frame_tick_count: got %0d pulses required 1", ticks);
    end
  endtask

  task automatic test_reset();
    int spurious = 0;
    sys_rst = 1'b0;
    band_if.band_valid = 1'b0;
    band_if.band_idx   = '0;
    band_if.band_level = '0;
    h_res = 11'd640;
    v_res = 11'd480;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      pixel_x = 11'(i * 70);
      pixel_y = 11'(479 - i * 50);
      repeat (2) @(negedge sys_clk);
      n_tests++;
      if (pixel_data !== BG || band_if.band_ready !== 1'b0 || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: pd=%h rdy=%b tick=%b required 0000 0 0",
                 pixel_data, band_if.band_ready, frame_tick);
      end
    end
    @(negedge sys_clk);
    pixel_x = 11'd0;
    pixel_y = 11'd0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    n_tests++;
    if (band_if.band_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b required 1", band_if.band_ready);
    end
    repeat (3) begin
      @(negedge sys_clk);
      if (frame_tick !== 1'b0) spurious++;
    end
    n_tests++;
    if (spurious !== 0) begin
      n_fail++;
      $display("FAIL no_spurious_swap: got %0d ticks required 0", spurious);
    end
    pixel_x = 11'd600;
    pixel_y = 11'd600;
    @(negedge sys_clk);
  endtask

  task automatic test_single_bar();
    logic [15:0] d;
    write_band(2, 100);
    do_frame();
    show(64, 479, d);
    n_tests++; if (d !== BAR)  begin n_fail++; $display("FAIL bar_64_479: got %h required %h", d, BAR); end
    show(91, 380, d);
    n_tests++; if (d !== BAR)  begin n_fail++; $display("FAIL bar_91_380: got %h required %h", d, BAR); end
    show(77, 420, d);
    n_tests++; if (d !== BAR)  begin n_fail++; $display("FAIL bar_77_420: got %h required %h", d, BAR); end
    show(70, 379, d);
    n_tests++; if (d !== PEAK) begin n_fail++; $display("FAIL peak_70_379: got %h required %h", d, PEAK); end
    show(64, 378, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL above_peak: got %h required %h", d, BG); end
    show(92, 400, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL gap_92: got %h required %h", d, BG); end
    show(95, 479, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL gap_95: got %h required %h", d, BG); end
    show(96, 479, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL band3_empty: got %h required %h", d, BG); end
  endtask

  task automatic test_double_buffer();
    logic [15:0] d;
    write_band(0, 50);
    show(0, 479, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL dbuf_before: got %h required %h", d, BG); end
    do_frame();
    show(0, 479, d);
    n_tests++; if (d !== BAR)  begin n_fail++; $display("FAIL dbuf_row0: got %h required %h", d, BAR); end
    show(10, 430, d);
    n_tests++; if (d !== BAR)  begin n_fail++; $display("FAIL dbuf_row49: got %h required %h", d, BAR); end
    show(10, 429, d);
    n_tests++; if (d !== PEAK) begin n_fail++; $display("FAIL dbuf_peak50: got %h required %h", d, PEAK); end
  endtask

  task automatic test_peak_decay();
    logic [15:0] d;
    write_band(5, 200);
    do_frame();
    for (int k = 1; k <= 8; k++) begin
      write_band(5, 10);
      do_frame();
      if (k <= 3) begin
        show(160, 279, d);
        n_tests++; if (d !== PEAK) begin n_fail++; $display("FAIL decay_hold f%0d: got %h required %h", k, d, PEAK); end
      end
      if (k == 4) begin
        show(160, 280, d);
        n_tests++; if (d !== PEAK) begin n_fail++; $display("FAIL decay_199: got %h required %h", d, PEAK); end
        show(160, 279, d);
        n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL decay_old_row: got %h required %h", d, BG); end
      end
      if (k == 8) begin
        show(160, 281, d);
        n_tests++; if (d !== PEAK) begin n_fail++; $display("FAIL decay_198: got %h required %h", d, PEAK); end
      end
      show(170, 470, d);
      n_tests++; if (d !== BAR) begin n_fail++; $display("FAIL decay_bar_top f%0d: got %h required %h", k, d, BAR); end
      show(170, 469, d);
      n_tests++; if (d !== BG)  begin n_fail++; $display("FAIL decay_bar_above f%0d: got %h required %h", k, d, BG); end
    end
  endtask

  task automatic test_collision();
    logic [15:0] d;
    @(negedge sys_clk);
    pixel_x = 11'd0;
    pixel_y = 11'd0;
    @(negedge sys_clk);
    band_if.band_valid = 1'b1;
    band_if.band_idx   = 5'd7;
    band_if.band_level = 8'd30;
    n_tests++;
    if (frame_tick !== 1'b1 || band_if.band_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_cycle: tick=%b rdy=%b required 1 0", frame_tick, band_if.band_ready);
    end
    @(negedge sys_clk);
    n_tests++;
    if (frame_tick !== 1'b0 || band_if.band_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_swap: tick=%b rdy=%b required 0 1", frame_tick, band_if.band_ready);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    band_if.band_valid = 1'b0;
    pixel_x = 11'd600;
    pixel_y = 11'd600;
    show(224, 479, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL collide_not_yet: got %h required %h", d, BG); end
    write_band(20, 99);
    do_frame();
    show(224, 479, d);
    n_tests++; if (d !== BAR)  begin n_fail++; $display("FAIL collide_landed: got %h required %h", d, BAR); end
    show(224, 449, d);
    n_tests++; if (d !== PEAK) begin n_fail++; $display("FAIL collide_peak: got %h required %h", d, PEAK); end
    show(128, 479, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL idx20_alias: got %h required %h", d, BG); end
  endtask

  task automatic test_boundaries();
    logic [15:0] d;
    show(512, 479, d);
    n_tests++; if (d !== BG) begin n_fail++; $display("FAIL x_512: got %h required %h", d, BG); end
    h_res = 11'd64;
    show(64, 479, d);
    n_tests++; if (d !== BG) begin n_fail++; $display("FAIL x_ge_hres: got %h required %h", d, BG); end
    h_res = 11'd640;
    show(64, 480, d);
    n_tests++; if (d !== BG) begin n_fail++; $display("FAIL y_ge_vres: got %h required %h", d, BG); end
    write_band(9, 255);
    do_frame();
    show(288, 479, d);
    n_tests++; if (d !== BAR)  begin n_fail++; $display("FAIL l255_row0: got %h required %h", d, BAR); end
    show(300, 225, d);
    n_tests++; if (d !== BAR)  begin n_fail++; $display("FAIL l255_row254: got %h required %h", d, BAR); end
    show(300, 224, d);
    n_tests++; if (d !== PEAK) begin n_fail++; $display("FAIL l255_peak: got %h required %h", d, PEAK); end
    show(300, 223, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL l255_row256: got %h required %h", d, BG); end
    show(315, 479, d);
    n_tests++; if (d !== BAR)  begin n_fail++; $display("FAIL col27: got %h required %h", d, BAR); end
    show(316, 479, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL col28_gap: got %h required %h", d, BG); end
    show(320, 479, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL zero_band_row0: got %h required %h", d, BG); end
    show(330, 478, d);
    n_tests++; if (d !== BG)   begin n_fail++; $display("FAIL zero_band_row1: got %h required %h", d, BG); end
  endtask

  initial begin
    test_reset();
    test_single_bar();
    test_double_buffer();
    test_peak_decay();
    test_collision();
    test_boundaries();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_spectrum_show.md
# lcd_spectrum_show

Pixel-data source for the LCD path: it renders a per-band audio level bar graph with peak-hold markers. It sits directly upstream of `lcd_driver`, in place of the static pattern generator. It takes `pixel_x`/`pixel_y`/`h_res`/`v_res` from the driver and returns `pixel_data`. Band levels arrive from the audio analysis side over a valid/ready write port into a double-buffered level store, which swaps once per frame so the picture never tears mid-frame.

## Interface
- `NUM_BANDS`, 16: number of bars; must be a power of 2, maximum 32.
- `LEVEL_W`, 8: level width; a level equals bar height in pixels.
- `BAND_SHIFT`, 5: log2 of bar pitch in pixels (32-pixel columns).
- `GAP`, 4: blank columns at the right of each pitch.
- `DECAY_FRAMES`, 4: frames without a new peak before the peak marker drops one pixel.
- `BAR_COLOR`, 16'h07E0; `PEAK_COLOR`, 16'hF800; `BG_COLOR`, 16'h0000: RGB565 colours.
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst`  in  1  asynchronous, active-low reset.
- `band_valid`  in  1  level write request.
- `band_ready`  out  1  write accepted when `band_valid && band_ready`.
- `band_idx`  in  5  band number.
- `band_level`  in  LEVEL_W  level value.
- `pixel_x`, `pixel_y`  in  11  current pixel position, from `lcd_driver`.
- `h_res`, `v_res`  in  11  active resolution, from `lcd_driver`.
- `pixel_data`  out  16  RGB565 pixel to `lcd_driver`.
- `frame_tick`  out  1  one-cycle pulse on a bank swap.

## Operation
- **Write bank.** `wr_lvl[NUM_BANDS]` receives each accepted write.
  - A `band_idx >= NUM_BANDS` write is accepted and discarded.
  - Repeated writes to one band within a frame: the last write wins.
  - An unwritten band keeps its previous value.
- **Frame start.** Detected when `(pixel_x==0 && pixel_y==0)` rises, sampled on `sys_clk`. The position holds for several `sys_clk` cycles because pclk is divided, so the edge detector fires exactly once per frame.
- **Swap cycle.** The swap happens in the cycle after the frame-start detection:
  - Copy `wr_lvl` to `disp_lvl`.
  - Update the peaks.
  - Pulse `frame_tick` for one cycle.
  - Hold `band_ready` low for that one cycle only; it is 1 on all other cycles.
- **Peak update, per band on each swap.**
  - If `new_lvl >= peak`: `peak <= new_lvl`, `dcnt <= 0`.
  - Otherwise, if `dcnt == DECAY_FRAMES-1`: `peak <= peak-1`, `dcnt <= 0`.
  - Otherwise: `dcnt <= dcnt+1`.
  - A decremented peak never goes below the level, because `new_lvl < peak` in that branch.
- **Pixel mapping.**
  - `band = pixel_x >> BAND_SHIFT`.
  - `col = pixel_x[BAND_SHIFT-1:0]`.
  - `row = v_res-1-pixel_y`: row counted from the bottom, computed at 11 bits.
- **Colour priority**, first match wins:
  1. `pixel_x >= h_res` or `pixel_y >= v_res` or `band >= NUM_BANDS` or `col >= (1<<BAND_SHIFT)-GAP`: `BG_COLOR`.
  2. `peak != 0` and `row == peak`: `PEAK_COLOR`.
  3. `row < disp_lvl[band]`: `BAR_COLOR`.
  4. Otherwise: `BG_COLOR`.
- **Width rule.** Comparisons zero-extend `LEVEL_W` to 11 bits. `row` values above `2^LEVEL_W-1` are never bar or peak pixels.

## Timing
- **Reset** (async assert, sync release): all outputs and state take these values.
  - Outputs: `pixel_data = BG_COLOR`, `band_ready = 0`, `frame_tick = 0`.
  - State: all `wr_lvl`, `disp_lvl`, `peak` and `dcnt` = 0; edge detector primed to 1, so no spurious swap if the position is (0,0) at release.
  - `band_ready` rises on the first clock after release.
- **Pixel latency: 2 `sys_clk` cycles.**
  - Stage 1 registers `band`, `row`, the blank flag and the gap flag.
  - Stage 2 reads `disp_lvl`/`peak`, compares, and registers `pixel_data`.
  - pclk is divided from `sys_clk` (at least 2:1), so the data settles before the next pclk edge.
- **Write latency.** A write in cycle t appears in `disp_lvl` after the next swap. It reaches `pixel_data` at the first pixel of the following frame.
- **Write/swap collision.** A write presented in the swap cycle sees `band_ready=0`. The producer holds `band_valid` and data stable; the write completes the next cycle and counts toward the next frame.
- **Reset mid-frame.** The display goes to background immediately (within 2 cycles of `pixel_data` being registered under reset). The peaks are lost.

## Test plan
- **Reset.** Hold `sys_rst=0`, sweep pixel positions → `pixel_data = 16'h0000`, `band_ready = 0`, `frame_tick = 0`. Release → `band_ready = 1` the next cycle.
- **Single bar.** Write band 2 = 100, run one frame start, then scan with `v_res=480`.
  - `pixel_x=64..91`, `pixel_y=380..479` → `16'h07E0`.
  - `pixel_y=379` → `16'hF800`.
  - `pixel_x=92..95` → `16'h0000`.
- **Double buffering.** Write band 0 = 50 mid-frame → bar height unchanged until the next frame start. It is 50 after the swap; `frame_tick` pulses exactly once per frame.
- **Peak decay.** Band 5: write 200, then 10 every frame.
  - Peak stays at 200 for frames 1..3.
  - Peak is 199 after frame 4 and 198 after frame 8.
  - The bar is 10 pixels high throughout.
- **Collision and out-of-range index.**
  - Assert `band_valid` on the swap cycle → `band_ready=0` for 1 cycle; the write lands in the next frame.
  - `band_idx=20` → accepted, no visible change.
- **Boundaries.**
  - `pixel_x >= 512` (outside the bands), `pixel_x >= h_res`, and `pixel_y >= v_res` → `BG_COLOR`.
  - Level 255 → bar rows 0..254; peak at row 255.
  - Level 0 with peak 0 → column entirely `BG_COLOR`.
